// File: rtl/simon_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simon_pkg : SIMON cipher constants, state encoding, word helpers   |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
package simon_pkg;

   localparam logic        MODE_64    = 1'b0;
   localparam logic        MODE_128   = 1'b1;
   localparam int unsigned ROUNDS_64  = 44;
   localparam int unsigned ROUNDS_128 = 68;

   // z[0] is the MSB of each constant.
   localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
   localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_KEXP = 2'd1,
      ST_BUSY = 2'd2
   } state_e;

   function automatic logic [6:0] num_rounds(input logic mode);
      return (mode == MODE_128) ? 7'(ROUNDS_128) : 7'(ROUNDS_64);
   endfunction

   function automatic logic [63:0] word_mask(input logic mode);
      return (mode == MODE_128) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   // Rotate within the active word size; upper half is zero in 64/128 mode.
   function automatic logic [63:0] rotl(input logic [63:0] v, input logic [5:0] j, input logic mode);
      logic [31:0] v32;
      v32 = v[31:0];
      if (mode == MODE_128)
         return (v << j) | (v >> (7'd64 - {1'b0, j}));
      return {32'd0, (v32 << j) | (v32 >> (6'd32 - j))};
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] v, input logic [5:0] j, input logic mode);
      return rotl(v, (mode == MODE_128) ? (6'd0 - j) : (6'd32 - j), mode);
   endfunction

   function automatic logic [63:0] simon_f(input logic [63:0] v, input logic mode);
      return (rotl(v, 6'd1, mode) & rotl(v, 6'd8, mode)) ^ rotl(v, 6'd2, mode);
   endfunction

   function automatic logic z_bit(input logic mode, input logic [5:0] i);
      return (mode == MODE_128) ? Z2[6'd61 - i] : Z3[6'd61 - i];
   endfunction

endpackage
`default_nettype wire

// File: rtl/simon_key_expansion.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simon_key_expansion : one-key-per-cycle generator and key store    |
// | Revision            : 1.0                                          |
// +--------------------------------------------------------------------+
module simon_key_expansion
   import simon_pkg::*;
(
   input  logic        clock,
   input  logic        nrst,
   input  logic        i_start,
   input  logic        i_mode,
   input  logic [63:0] i_key_l,
   input  logic [63:0] i_key_h,
   input  logic [6:0]  i_rd_idx,
   output logic [63:0] o_rd_key,
   output logic        o_mode,
   output logic        o_done
);

   logic [63:0]      store_q [ROUNDS_128];
   logic [3:0][63:0] win_q, win_d;
   logic [6:0]       idx_q, idx_d;
   logic [5:0]       zi_q, zi_d;
   logic             mode_q, mode_d;
   logic             active_q, active_d;
   logic             done_q, done_d;

   logic [6:0]  n_words;
   logic [63:0] mask, t0, t1, new_key, wr_data;

   // Window holds the last n_words keys, oldest in slot 0.
   always_comb begin
      mode_d   = mode_q;
      active_d = active_q;
      done_d   = done_q;
      idx_d    = idx_q;
      zi_d     = zi_q;
      win_d    = win_q;

      mask    = word_mask(mode_q);
      n_words = (mode_q == MODE_128) ? 7'd2 : 7'd4;
      if (mode_q == MODE_128)
         t0 = rotr(win_q[1], 6'd3, mode_q);
      else
         t0 = rotr(win_q[3], 6'd3, mode_q) ^ win_q[1];
      t1      = t0 ^ rotr(t0, 6'd1, mode_q);
      new_key = (~win_q[0] ^ t1 ^ {63'd0, z_bit(mode_q, zi_q)} ^ 64'd3) & mask;
      wr_data = (idx_q < n_words) ? win_q[idx_q[1:0]] : new_key;

      if (i_start) begin
         mode_d   = i_mode;
         active_d = 1'b1;
         done_d   = 1'b0;
         idx_d    = '0;
         zi_d     = '0;
         if (i_mode == MODE_128)
            win_d = {64'd0, 64'd0, i_key_h, i_key_l};
         else
            win_d = {{32'd0, i_key_h[63:32]}, {32'd0, i_key_h[31:0]},
                     {32'd0, i_key_l[63:32]}, {32'd0, i_key_l[31:0]}};
      end else if (active_q) begin
         idx_d = idx_q + 7'd1;
         if (idx_q >= n_words) begin
            zi_d     = (zi_q == 6'd61) ? '0 : zi_q + 6'd1;
            win_d[0] = win_q[1];
            if (mode_q == MODE_128) begin
               win_d[1] = new_key;
            end else begin
               win_d[1] = win_q[2];
               win_d[2] = win_q[3];
               win_d[3] = new_key;
            end
         end
         if (idx_q == num_rounds(mode_q) - 7'd1) begin
            active_d = 1'b0;
            done_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!nrst) begin
         win_q    <= '0;
         idx_q    <= '0;
         zi_q     <= '0;
         mode_q   <= 1'b0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         win_q    <= win_d;
         idx_q    <= idx_d;
         zi_q     <= zi_d;
         mode_q   <= mode_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   always_ff @(posedge clock) begin
      if (active_q)
         store_q[idx_q] <= wr_data;
   end

   assign o_rd_key = store_q[i_rd_idx];
   assign o_mode   = mode_q;
   assign o_done   = done_q;

endmodule
`default_nettype wire

// File: rtl/simon_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simon_core : iterative SIMON 64/128 and 128/128 enc/dec datapath   |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module simon_core
   import simon_pkg::*;
(
   input  logic        clock,
   input  logic        nrst,
   input  logic [63:0] io_keyL,
   input  logic [63:0] io_keyH,
   input  logic        io_kValid,
   output logic        io_kExpDone,
   input  logic        io_sMode,
   input  logic [63:0] io_data1In,
   input  logic [63:0] io_data2In,
   output logic [63:0] io_data1Out,
   output logic [63:0] io_data2Out,
   output logic        io_dInReady,
   input  logic        io_dInValid,
   output logic        io_dOutValid,
   input  logic        io_dEncDec,
   input  logic        io_rSingle
);

   state_e      state_q, state_d;
   logic [6:0]  ptr_q, ptr_d, rnd_q, rnd_d;
   logic [63:0] x_q, x_d, y_q, y_d, out1_q, out1_d, out2_q, out2_d;
   logic        enc_q, enc_d, single_q, single_d, dout_valid_q, dout_valid_d;

   logic        kexp_start, kexp_done, key_mode, last_round;
   logic [6:0]  n_rounds, ptr_inc, ptr_dec, rd_idx;
   logic [63:0] rd_key, mask, x_nxt, y_nxt;

   assign kexp_start = (state_q == ST_IDLE) && io_kValid;

   simon_key_expansion u_kexp (
      .clock    (clock),
      .nrst     (nrst),
      .i_start  (kexp_start),
      .i_mode   (io_sMode),
      .i_key_l  (io_keyL),
      .i_key_h  (io_keyH),
      .i_rd_idx (rd_idx),
      .o_rd_key (rd_key),
      .o_mode   (key_mode),
      .o_done   (kexp_done)
   );

   // Single decrypt steps back first, so it uses the decremented pointer.
   always_comb begin
      n_rounds = num_rounds(key_mode);
      mask     = word_mask(key_mode);
      ptr_inc  = (ptr_q == n_rounds - 7'd1) ? '0 : ptr_q + 7'd1;
      ptr_dec  = (ptr_q == '0) ? n_rounds - 7'd1 : ptr_q - 7'd1;
      if (single_q)
         rd_idx = enc_q ? ptr_q : ptr_dec;
      else
         rd_idx = enc_q ? rnd_q : n_rounds - 7'd1 - rnd_q;
      if (enc_q) begin
         x_nxt = y_q ^ simon_f(x_q, key_mode) ^ rd_key;
         y_nxt = x_q;
      end else begin
         x_nxt = y_q;
         y_nxt = x_q ^ simon_f(y_q, key_mode) ^ rd_key;
      end
      last_round = single_q || (rnd_q == n_rounds - 7'd1);
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      rnd_d        = rnd_q;
      x_d          = x_q;
      y_d          = y_q;
      enc_d        = enc_q;
      single_d     = single_q;
      dout_valid_d = dout_valid_q;
      out1_d       = out1_q;
      out2_d       = out2_q;

      case (state_q)
         ST_IDLE: begin
            if (io_kValid) begin
               state_d      = ST_KEXP;
               ptr_d        = '0;
               dout_valid_d = 1'b0;
            end else if (kexp_done && io_dInValid) begin
               state_d      = ST_BUSY;
               x_d          = io_data1In & mask;
               y_d          = io_data2In & mask;
               enc_d        = io_dEncDec;
               single_d     = io_rSingle;
               rnd_d        = '0;
               dout_valid_d = 1'b0;
            end
         end
         ST_KEXP: begin
            if (kexp_done) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end
         end
         ST_BUSY: begin
            x_d   = x_nxt;
            y_d   = y_nxt;
            rnd_d = rnd_q + 7'd1;
            if (single_q)
               ptr_d = enc_q ? ptr_inc : ptr_dec;
            if (last_round) begin
               state_d      = ST_IDLE;
               dout_valid_d = 1'b1;
               out1_d       = x_nxt;
               out2_d       = y_nxt;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!nrst) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         rnd_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         enc_q        <= 1'b0;
         single_q     <= 1'b0;
         dout_valid_q <= 1'b0;
         out1_q       <= '0;
         out2_q       <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         rnd_q        <= rnd_d;
         x_q          <= x_d;
         y_q          <= y_d;
         enc_q        <= enc_d;
         single_q     <= single_d;
         dout_valid_q <= dout_valid_d;
         out1_q       <= out1_d;
         out2_q       <= out2_d;
      end
   end

   assign io_kExpDone  = kexp_done;
   assign io_dInReady  = (state_q == ST_IDLE) && kexp_done;
   assign io_dOutValid = dout_valid_q;
   assign io_data1Out  = out1_q;
   assign io_data2Out  = out2_q;

endmodule
`default_nettype wire

// File: tb/tb_simon_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_simon_core : randomized bench with array-based SIMON model      |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module tb_simon_core;

   localparam logic [61:0] TZ2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
   localparam logic [61:0] TZ3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

   logic        clock = 1'b0;
   logic        nrst;
   logic [63:0] io_keyL, io_keyH, io_data1In, io_data2In;
   logic [63:0] io_data1Out, io_data2Out;
   logic        io_kValid, io_kExpDone, io_sMode, io_dInReady, io_dInValid;
   logic        io_dOutValid, io_dEncDec, io_rSingle;

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0] m_rk [0:67];
   int          m_n, m_T, m_ptr;

   always #5 clock = ~clock;

   simon_core dut (
      .clock        (clock),
      .nrst         (nrst),
      .io_keyL      (io_keyL),
      .io_keyH      (io_keyH),
      .io_kValid    (io_kValid),
      .io_kExpDone  (io_kExpDone),
      .io_sMode     (io_sMode),
      .io_data1In   (io_data1In),
      .io_data2In   (io_data2In),
      .io_data1Out  (io_data1Out),
      .io_data2Out  (io_data2Out),
      .io_dInReady  (io_dInReady),
      .io_dInValid  (io_dInValid),
      .io_dOutValid (io_dOutValid),
      .io_dEncDec   (io_dEncDec),
      .io_rSingle   (io_rSingle)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] m_mask();
      return (m_n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   function automatic logic [63:0] m_rol(input logic [63:0] v, input int j);
      logic [63:0] w;
      w = v & m_mask();
      return ((w << j) | (w >> (m_n - j))) & m_mask();
   endfunction

   function automatic logic [63:0] m_f(input logic [63:0] v);
      return (m_rol(v, 1) & m_rol(v, 8)) ^ m_rol(v, 2);
   endfunction

   task automatic model_expand(input logic [63:0] kl, input logic [63:0] kh, input logic mode);
      int          m;
      logic [63:0] t;
      logic        zb;
      m_n = mode ? 64 : 32;
      m_T = mode ? 68 : 44;
      m   = mode ? 2 : 4;
      if (mode) begin
         m_rk[0] = kl;
         m_rk[1] = kh;
      end else begin
         m_rk[0] = {32'd0, kl[31:0]};
         m_rk[1] = {32'd0, kl[63:32]};
         m_rk[2] = {32'd0, kh[31:0]};
         m_rk[3] = {32'd0, kh[63:32]};
      end
      for (int i = 0; i < m_T - m; i++) begin
         t = m_rol(m_rk[i+m-1], m_n - 3);
         if (m == 4) t = t ^ m_rk[i+1];
         t  = t ^ m_rol(t, m_n - 1);
         zb = mode ? TZ2[61 - (i % 62)] : TZ3[61 - (i % 62)];
         m_rk[i+m] = (~m_rk[i] ^ t ^ 64'(zb) ^ 64'd3) & m_mask();
      end
      m_ptr = 0;
   endtask

   task automatic m_round(inout logic [63:0] x, inout logic [63:0] y, input logic [63:0] k, input logic enc);
      logic [63:0] tmp;
      if (enc) begin
         tmp = x;
         x   = y ^ m_f(x) ^ k;
         y   = tmp;
      end else begin
         tmp = y;
         y   = x ^ m_f(y) ^ k;
         x   = tmp;
      end
   endtask

   task automatic load_key(input logic [63:0] kl, input logic [63:0] kh, input logic mode);
      int n;
      @(negedge clock);
      io_keyL   = kl;
      io_keyH   = kh;
      io_sMode  = mode;
      io_kValid = 1'b1;
      @(negedge clock);
      io_kValid = 1'b0;
      io_keyL   = {$urandom, $urandom};
      io_keyH   = {$urandom, $urandom};
      io_sMode  = ~mode;
      check("kexp_cleared", 64'(io_kExpDone), 64'd0);
      n = 0;
      while (!io_kExpDone && n < 300) begin
         @(negedge clock);
         n++;
      end
      check("kexp_done", 64'(io_kExpDone), 64'd1);
      model_expand(kl, kh, mode);
   endtask

   task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic enc, input logic single,
                         output logic [63:0] ox, output logic [63:0] oy);
      int          lat;
      logic [63:0] ex, ey, k;
      ex = x & m_mask();
      ey = y & m_mask();
      if (single) begin
         if (enc) begin
            k     = m_rk[m_ptr];
            m_ptr = (m_ptr + 1) % m_T;
         end else begin
            m_ptr = (m_ptr + m_T - 1) % m_T;
            k     = m_rk[m_ptr];
         end
         m_round(ex, ey, k, enc);
      end else begin
         for (int r = 0; r < m_T; r++)
            m_round(ex, ey, enc ? m_rk[r] : m_rk[m_T-1-r], enc);
      end
      @(negedge clock);
      check("ready", 64'(io_dInReady), 64'd1);
      io_data1In  = x;
      io_data2In  = y;
      io_dEncDec  = enc;
      io_rSingle  = single;
      io_dInValid = 1'b1;
      @(negedge clock);
      io_dInValid = 1'b0;
      io_data1In  = {$urandom, $urandom};
      io_data2In  = {$urandom, $urandom};
      io_dEncDec  = ~enc;
      io_rSingle  = ~single;
      lat = 1;
      while (!io_dOutValid && lat < 200) begin
         @(negedge clock);
         lat++;
      end
      check("latency", 64'(lat), single ? 64'd2 : 64'(m_T + 1));
      ox = io_data1Out;
      oy = io_data2Out;
      check("x_out", ox, ex);
      check("y_out", oy, ey);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_d1"}, io_data1Out, 64'd0);
      check({tag, "_d2"}, io_data2Out, 64'd0);
      check({tag, "_kexp"}, 64'(io_kExpDone), 64'd0);
      check({tag, "_rdy"}, 64'(io_dInReady), 64'd0);
      check({tag, "_dov"}, 64'(io_dOutValid), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] ox, oy, cx, cy, px, py, sx, sy;
      nrst = 1'b0;
      io_keyL = '0; io_keyH = '0; io_kValid = 1'b0; io_sMode = 1'b0;
      io_data1In = '0; io_data2In = '0; io_dInValid = 1'b0; io_dEncDec = 1'b0; io_rSingle = 1'b0;
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      nrst = 1'b1;

      // Requests before any key are dropped.
      io_dInValid = 1'b1;
      repeat (3) @(negedge clock);
      io_dInValid = 1'b0;
      check("early_rdy", 64'(io_dInReady), 64'd0);
      check("early_dov", 64'(io_dOutValid), 64'd0);

      // Simon64/128 known answer, full then single-step chains.
      load_key(64'h0B0A0908_03020100, 64'h1B1A1918_13121110, 1'b0);
      run_op(64'h656B696C, 64'h20646E75, 1'b1, 1'b0, ox, oy);
      check("kat64_x", ox, 64'h44C8FC20);
      check("kat64_y", oy, 64'hB9DFA07A);
      sx = 64'h656B696C; sy = 64'h20646E75;
      for (int i = 0; i < 44; i++) begin
         run_op(sx, sy, 1'b1, 1'b1, ox, oy);
         sx = ox; sy = oy;
      end
      check("chain64_x", sx, 64'h44C8FC20);
      check("chain64_y", sy, 64'hB9DFA07A);
      for (int i = 0; i < 44; i++) begin
         run_op(sx, sy, 1'b0, 1'b1, ox, oy);
         sx = ox; sy = oy;
      end
      check("unchain64_x", sx, 64'h656B696C);
      check("unchain64_y", sy, 64'h20646E75);

      // Simon128/128 known answer, encrypt and decrypt.
      load_key(64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 1'b1);
      run_op(64'h6373656420737265, 64'h6C6C657661727420, 1'b1, 1'b0, cx, cy);
      check("kat128_x", cx, 64'h49681B1E1E54FE3F);
      check("kat128_y", cy, 64'h65AA832AF84E0BBC);
      run_op(cx, cy, 1'b0, 1'b0, px, py);
      check("dec128_x", px, 64'h6373656420737265);
      check("dec128_y", py, 64'h6C6C657661727420);

      // Pointer wrap: 45 single steps forward then 45 back.
      load_key(64'h0042AA2AFF020180, 64'h56AB09BBA4F93011, 1'b0);
      sx = 64'h03020100; sy = 64'h07060504;
      for (int i = 0; i < 45; i++) begin
         run_op(sx, sy, 1'b1, 1'b1, ox, oy);
         sx = ox; sy = oy;
      end
      for (int i = 0; i < 45; i++) begin
         run_op(sx, sy, 1'b0, 1'b1, ox, oy);
         sx = ox; sy = oy;
      end
      check("wrap_x", sx, 64'h03020100);
      check("wrap_y", sy, 64'h07060504);

      // Random keys, modes and operations.
      for (int kk = 0; kk < 4; kk++) begin
         load_key({$urandom, $urandom}, {$urandom, $urandom}, kk[0]);
         for (int op = 0; op < 8; op++)
            run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ox, oy);
      end

      // New request while busy is ignored and not queued.
      begin
         int lat;
         logic [63:0] ex, ey;
         ex = 64'h1234_5678_9ABC_DEF0 & m_mask();
         ey = 64'h0FED_CBA9_8765_4321 & m_mask();
         for (int r = 0; r < m_T; r++)
            m_round(ex, ey, m_rk[r], 1'b1);
         @(negedge clock);
         io_data1In = 64'h1234_5678_9ABC_DEF0; io_data2In = 64'h0FED_CBA9_8765_4321;
         io_dEncDec = 1'b1; io_rSingle = 1'b0; io_dInValid = 1'b1;
         @(negedge clock);
         io_data1In = '1; io_data2In = '0; io_dEncDec = 1'b0; io_rSingle = 1'b1;
         repeat (3) @(negedge clock);
         check("busy_rdy", 64'(io_dInReady), 64'd0);
         io_dInValid = 1'b0;
         lat = 4;
         while (!io_dOutValid && lat < 200) begin
            @(negedge clock);
            lat++;
         end
         check("busy_lat", 64'(lat), 64'(m_T + 1));
         check("busy_x", io_data1Out, ex);
         check("busy_y", io_data2Out, ey);
         repeat (3) @(negedge clock);
         check("noqueue_dov", 64'(io_dOutValid), 64'd1);
         check("noqueue_x", io_data1Out, ex);
      end

      // kValid while idle clears kExpDone and dOutValid.
      @(negedge clock);
      io_keyL = 64'h0B0A0908_03020100; io_keyH = 64'h1B1A1918_13121110; io_sMode = 1'b0;
      io_kValid = 1'b1;
      @(negedge clock);
      io_kValid = 1'b0;
      check("rekey_kexp", 64'(io_kExpDone), 64'd0);
      check("rekey_dov", 64'(io_dOutValid), 64'd0);
      check("rekey_rdy", 64'(io_dInReady), 64'd0);
      repeat (60) @(negedge clock);
      check("rekey_done", 64'(io_kExpDone), 64'd1);
      model_expand(64'h0B0A0908_03020100, 64'h1B1A1918_13121110, 1'b0);
      run_op(64'h656B696C, 64'h20646E75, 1'b1, 1'b0, ox, oy);

      // Reset during BUSY aborts everything.
      @(negedge clock);
      io_dInValid = 1'b1; io_dEncDec = 1'b1; io_rSingle = 1'b0;
      @(negedge clock);
      io_dInValid = 1'b0;
      repeat (5) @(negedge clock);
      nrst = 1'b0;
      @(negedge clock);
      check_all_zero("rst_busy");
      nrst = 1'b1;
      io_dInValid = 1'b1;
      repeat (5) @(negedge clock);
      io_dInValid = 1'b0;
      check("rst_busy_rdy", 64'(io_dInReady), 64'd0);
      check("rst_busy_dov", 64'(io_dOutValid), 64'd0);

      // Reset during KEXP leaves the key store invalid.
      @(negedge clock);
      io_kValid = 1'b1;
      @(negedge clock);
      io_kValid = 1'b0;
      repeat (10) @(negedge clock);
      nrst = 1'b0;
      @(negedge clock);
      check_all_zero("rst_kexp");
      nrst = 1'b1;
      repeat (80) @(negedge clock);
      check("rst_kexp_done", 64'(io_kExpDone), 64'd0);
      check("rst_kexp_rdy", 64'(io_dInReady), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
